// File: rtl/spike_net_pkg.sv
// Shared constants for the spike network responder: spike codes, FSM states
// and the default broadcast word width.
package spike_net_pkg;

  localparam int DEF_TEN_DATA_WIDTH  = 2;
  localparam int DEF_NEURON_ID_WIDTH = 9;
  localparam int SPIKE_IN_WIDTH      = DEF_TEN_DATA_WIDTH + DEF_NEURON_ID_WIDTH;

  localparam logic [1:0] SPK_NONE = 2'd0;
  localparam logic [1:0] SPK_POS  = 2'd1;
  localparam logic [1:0] SPK_NEG  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/net_ready_detect.sv
// Masked AND of per-neuron network requests: only indices below active_neuron
// participate, and an empty population is never ready.
module net_ready_detect
  import spike_net_pkg::*;
#(
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = 9
) (
  input  logic [NUM_NEURON-1:0]      en_network_vec,
  input  logic [NEURON_ID_WIDTH-1:0] active_neuron,
  output logic                       ready
);

  always_comb begin
    ready = (active_neuron != '0);
    for (int i = 0; i < NUM_NEURON; i++) begin
      if ((i < int'(active_neuron)) && !en_network_vec[i]) ready = 1'b0;
    end
  end

endmodule

// File: rtl/spike_network.sv
// Network-phase responder: snapshots spike codes, scans for one winner and
// broadcasts it. Define SPIKE_NET_ROUND_ROBIN_EN for a rotating scan start.
module spike_network
  import spike_net_pkg::*;
#(
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = 9,
  parameter int ITER_WIDTH      = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_l,
  input  logic                                   en_net,
  input  logic [NEURON_ID_WIDTH-1:0]             active_neuron,
  input  logic [NUM_NEURON-1:0]                  en_network_vec,
  input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]   spike_out_vec,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
  output logic                                   networkDone,
  output logic                                   net_busy,
  output logic [ITER_WIDTH-1:0]                  iter_count
);

  localparam int SPK_W = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
  localparam logic [NEURON_ID_WIDTH:0]   ONE_WIDE = 1;
  localparam logic [NEURON_ID_WIDTH-1:0] ONE_ID   = 1;
  localparam logic [ITER_WIDTH-1:0]      ONE_IT   = 1;

  state_t state, state_next;

  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0] snapshot;
  logic [NEURON_ID_WIDTH-1:0] offset;
  logic [NEURON_ID_WIDTH-1:0] ptr;
  logic [NEURON_ID_WIDTH-1:0] cand;
  logic [NEURON_ID_WIDTH:0]   cand_sum;
  logic [TEN_DATA_WIDTH-1:0]  cand_code;
  logic                       cand_hit;
  logic                       scan_last;
  logic                       ready;

  net_ready_detect #(
    .NUM_NEURON      (NUM_NEURON),
    .NEURON_ID_WIDTH (NEURON_ID_WIDTH)
  ) u_ready (
    .en_network_vec (en_network_vec),
    .active_neuron  (active_neuron),
    .ready          (ready)
  );

  // Candidate index wraps at active_neuron; ptr and offset are both below it.
  always_comb begin
    cand_sum = {1'b0, ptr} + {1'b0, offset};
    if (cand_sum >= {1'b0, active_neuron}) cand_sum = cand_sum - {1'b0, active_neuron};
    cand      = cand_sum[NEURON_ID_WIDTH-1:0];
    cand_code = snapshot[int'(cand)*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
    cand_hit  = (cand_code == SPK_POS) || (cand_code == SPK_NEG);
    scan_last = (({1'b0, offset} + ONE_WIDE) >= {1'b0, active_neuron});
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (ready) state_next = ST_SCAN;
      ST_SCAN: if (cand_hit || scan_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign net_busy = (state != ST_IDLE);

  // The broadcast word and pulse are registered on entry to DONE so both are
  // visible during the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state       <= ST_IDLE;
      spike_in    <= '0;
      networkDone <= 1'b0;
      iter_count  <= '0;
      snapshot    <= '0;
      offset      <= '0;
    end else if (en_net) begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (ready) begin
            snapshot <= spike_out_vec;
            offset   <= '0;
          end
        end
        ST_SCAN: begin
          if (cand_hit) begin
            spike_in    <= {cand_code, cand};
            networkDone <= 1'b1;
          end else if (scan_last) begin
            spike_in    <= '0;
            networkDone <= 1'b1;
          end else begin
            offset <= offset + ONE_ID;
          end
        end
        ST_DONE: begin
          networkDone <= 1'b0;
          iter_count  <= iter_count + ONE_IT;
        end
        default: ;
      endcase
    end
  end

`ifdef SPIKE_NET_ROUND_ROBIN_EN
  logic [NEURON_ID_WIDTH:0] ptr_inc;
  logic                     win_hit;

  // A nonzero code in the broadcast word means this phase had a winner.
  assign ptr_inc = {1'b0, spike_in[NEURON_ID_WIDTH-1:0]} + ONE_WIDE;
  assign win_hit = (spike_in[SPK_W-1 -: TEN_DATA_WIDTH] != '0);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      ptr <= '0;
    end else if (en_net && (state == ST_DONE) && win_hit) begin
      ptr <= (ptr_inc >= {1'b0, active_neuron}) ? '0 : ptr_inc[NEURON_ID_WIDTH-1:0];
    end
  end
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_spike_network.sv
// Scoreboard bench for spike_network: a scan-order reference model pushes
// expected broadcasts; a monitor checks each networkDone pulse.
module tb_spike_network;

  logic          clk = 1'b0;
  logic          reset_l;
  logic          en_net;
  logic [8:0]    active_neuron;
  logic [511:0]  en_network_vec;
  logic [1023:0] spike_out_vec;
  logic [10:0]   spike_in;
  logic          networkDone;
  logic          net_busy;
  logic [15:0]   iter_count;

  spike_network dut (
    .clk            (clk),
    .reset_l        (reset_l),
    .en_net         (en_net),
    .active_neuron  (active_neuron),
    .en_network_vec (en_network_vec),
    .spike_out_vec  (spike_out_vec),
    .spike_in       (spike_in),
    .networkDone    (networkDone),
    .net_busy       (net_busy),
    .iter_count     (iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] word;
    int          iter;
    int          done_cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [1:0] codes[512];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  int         model_p = 0;
  int         model_iter = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: walk the candidates in scan order from the start pointer.
  task automatic ref_pick(input int n, input int p, output logic [10:0] word,
                          output int lat, output int newp);
    word = '0;
    lat  = 1 + n;
    newp = p;
    for (int j = 0; j < n; j++) begin
      int k;
      k = (p + j) % n;
      if (codes[k] == 2'd1 || codes[k] == 2'd2) begin
        word = {codes[k], 9'(k)};
        lat  = 2 + j;
`ifdef SPIKE_NET_ROUND_ROBIN_EN
        newp = (k + 1) % n;
`endif
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_l && en_net && networkDone) begin
      if (sbq.size() == 0) begin
        check("spurious_pulse", 32'(networkDone), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("spike_in", 32'(spike_in), 32'(e.word));
        check("iter_at_done", 32'(iter_count), 32'(e.iter[15:0]));
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
        check("busy_at_done", 32'(net_busy), 32'd1);
      end
      done_cnt++;
    end
  end

  task automatic drive_codes();
    for (int i = 0; i < 512; i++) spike_out_vec[2*i +: 2] = codes[i];
  endtask

  task automatic rand_codes(input int n);
    for (int i = 0; i < 512; i++) begin
      int r;
      r = $urandom_range(0, 15);
      codes[i] = (i < n && r < 3) ? 2'(r + 1) : 2'(r & 3);
    end
  endtask

  task automatic clear_codes();
    for (int i = 0; i < 512; i++) codes[i] = 2'd0;
  endtask

  // One network phase: present requests, predict, scramble inputs, await pulse.
  task automatic phase(input int n, input bit stall, input bit drop5);
    logic [10:0] w;
    int lat, newp, start, guard;
    exp_t e;
    @(negedge clk);
    drive_codes();
    for (int i = 0; i < 512; i++) en_network_vec[i] = (i < n) ? 1'b1 : 1'($urandom_range(0, 1));
    if (drop5) en_network_vec[5] = 1'b0;
    active_neuron = 9'(n);
    ref_pick(n, model_p, w, lat, newp);
    e.word = w;
    e.iter = model_iter;
    e.done_cyc = cyc + lat + (stall ? 3 : 0);
    sbq.push_back(e);
    model_iter++;
    model_p = newp;
    start = done_cnt;
    @(negedge clk);
    for (int i = 0; i < 512; i++) en_network_vec[i] = 1'($urandom_range(0, 1));
    en_network_vec[0] = 1'b0;
    for (int i = 0; i < 1024; i++) spike_out_vec[i] = 1'($urandom_range(0, 1));
    if (stall) begin
      en_net = 1'b0;
      repeat (3) @(negedge clk);
      en_net = 1'b1;
    end
    guard = 0;
    while (done_cnt == start && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (done_cnt == start) begin
      check("phase_timeout", 32'(done_cnt), 32'(start + 1));
      void'(sbq.pop_front());
    end
    repeat (4) @(negedge clk);
  endtask

  logic [10:0] rr_exp[3];

  initial begin
    reset_l = 1'b0;
    en_net = 1'b1;
    active_neuron = '0;
    en_network_vec = '0;
    spike_out_vec = '0;
    repeat (3) @(negedge clk);
    check("rst_spike_in", 32'(spike_in), 32'd0);
    check("rst_done", 32'(networkDone), 32'd0);
    check("rst_busy", 32'(net_busy), 32'd0);
    check("rst_iter", 32'(iter_count), 32'd0);
    reset_l = 1'b1;

    clear_codes();
    codes[2] = 2'd1;
    phase(4, 1'b0, 1'b0);
    check("single_spike_word", 32'(spike_in), 32'h202);
    check("single_spike_iter", 32'(iter_count), 32'd1);

    clear_codes();
    phase(4, 1'b0, 1'b0);
    check("no_spike_word", 32'(spike_in), 32'h000);
    check("no_spike_iter", 32'(iter_count), 32'd2);

    @(negedge clk);
    active_neuron = 9'd4;
    en_network_vec = '1;
    en_network_vec[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_neuron0_missing", 32'(net_busy), 32'd0);
    active_neuron = 9'd0;
    en_network_vec = '1;
    repeat (10) @(negedge clk);
    check("idle_zero_active", 32'(net_busy), 32'd0);
    en_network_vec = '0;

    clear_codes();
    drive_codes();
    active_neuron = 9'd8;
    en_network_vec[7:0] = 8'hff;
    repeat (3) @(negedge clk);
    check("busy_mid_scan", 32'(net_busy), 32'd1);
    reset_l = 1'b0;
    en_network_vec = '0;
    @(negedge clk);
    check("abort_spike_in", 32'(spike_in), 32'd0);
    check("abort_done", 32'(networkDone), 32'd0);
    check("abort_busy", 32'(net_busy), 32'd0);
    check("abort_iter", 32'(iter_count), 32'd0);
    reset_l = 1'b1;
    model_iter = 0;
    model_p = 0;

`ifdef SPIKE_NET_ROUND_ROBIN_EN
    rr_exp = '{11'h401, 11'h403, 11'h401};
`else
    rr_exp = '{11'h401, 11'h401, 11'h401};
`endif
    for (int r = 0; r < 3; r++) begin
      clear_codes();
      codes[1] = 2'd2;
      codes[3] = 2'd2;
      phase(4, 1'b0, 1'b0);
      check("arbitration_word", 32'(spike_in), 32'(rr_exp[r]));
    end

    clear_codes();
    codes[0] = 2'd3;
    codes[1] = 2'd1;
    phase(4, 1'b0, 1'b0);
    check("illegal_skipped", 32'(spike_in), 32'h201);

    clear_codes();
    codes[3] = 2'd2;
    phase(4, 1'b1, 1'b1);
    check("stall_word", 32'(spike_in), 32'h403);

    for (int t = 0; t < 25; t++) begin
      int n;
      n = (t % 8 == 7) ? 511 : $urandom_range(1, 20);
      rand_codes(n);
      phase(n, 1'($urandom_range(0, 3) == 0), 1'b0);
    end

    check("final_iter", 32'(iter_count), 32'(model_iter));
    check("queue_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
